// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, FIFO depth defaults
// and the read-side state encoding used by uart_tx_fifo.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_BUSY_WAIT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage with wrapping write/read pointers and a registered,
// reset-able read port that only updates when a word is popped.
module sync_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q;

  // DEPTH is a power of two, so the pointers wrap simply by overflowing.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (rd_en_i) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between control and uart_tx; meters bytes out on the busy handshake.
// Optional drop/launch counters are built when UART_TX_FIFO_STATS_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = UART_FIFO_DEPTH,
  localparam int ADDR_W   = $clog2(DEPTH),
  parameter int BUSY_WAIT = UART_BUSY_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_din,
  input  logic              wr_vld,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_din,
  output logic              tx_vld
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       sent_cnt
`endif
);

  localparam int GUARD_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(BUSY_WAIT - 1);
  localparam logic [ADDR_W:0]    LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]    LEVEL_ONE  = (ADDR_W + 1)'(1);

  tx_state_e          state_q;
  logic [GUARD_W-1:0] guard_q;
  logic               tx_vld_q;
  logic [ADDR_W:0]    level_q, level_d;
  logic               full_q, empty_q, overflow_q;
  logic               push, pop, drop;

  // full_q is registered, so a pop in this cycle never frees room for this cycle's write.
  assign push = wr_vld & ~full_q;
  assign drop = wr_vld &  full_q;
  assign pop  = (state_q == ST_LAUNCH);

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (wr_din),
    .rd_en_i   (pop),
    .rd_data_o (tx_din)
  );

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LEVEL_FULL);
      empty_q <= (level_d == '0);
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      guard_q  <= '0;
      tx_vld_q <= 1'b0;
    end else begin
      tx_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0 && !tx_busy) state_q <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          tx_vld_q <= 1'b1;
          guard_q  <= '0;
          state_q  <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          // A transmitter that never raises busy is assumed to have taken the byte.
          if (tx_busy) begin
            state_q <= ST_WAIT_LO;
          end else if (guard_q == GUARD_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            guard_q <= guard_q + GUARD_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_vld   = tx_vld_q;

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] drop_cnt_q, sent_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      sent_cnt_q <= '0;
    end else begin
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (pop) sent_cnt_q <= sent_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign sent_cnt = sent_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple uart_tx busy model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_din = 8'h00;
  logic       wr_vld = 1'b0;
  logic       full, empty, overflow;
  logic [4:0] level;
  logic       tx_busy;
  logic [7:0] tx_din;
  logic       tx_vld;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] drop_cnt, sent_cnt;
`endif

  uart_tx_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .wr_din   (wr_din),
    .wr_vld   (wr_vld),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx_din   (tx_din),
    .tx_vld   (tx_vld)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .drop_cnt (drop_cnt),
    .sent_cnt (sent_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Busy source: either a forced level or an emulated transmitter that raises
  // busy the cycle after it sees tx_vld and holds it for busy_len cycles.
  logic auto_mode = 1'b0;
  logic busy_force = 1'b0;
  logic emu_busy = 1'b0;
  int   busy_len = 10;
  assign tx_busy = auto_mode ? emu_busy : busy_force;

  logic [7:0] got[$];
  int         got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_vld) begin
      got.push_back(tx_din);
      got_cyc.push_back(cyc);
      $display("[%0d] launch byte %02h", cyc, tx_din);
    end
  end

  initial begin : busy_emu
    int   cnt;
    logic seen;
    cnt = 0;
    forever begin
      @(negedge clk);
      seen = tx_vld;
      @(posedge clk);
      #1;
      if (!auto_mode) begin
        cnt = 0;
      end else begin
        if (cnt > 0) cnt--;
        if (seen) cnt = busy_len;
      end
      emu_busy = (cnt > 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s = %0h", tag, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_vld = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    wr_din = b;
    wr_vld = 1'b1;
    step(1);
    wr_vld = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) step(1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, wc, v;

    // Reset state
    step(2);
    do_reset();
    check("rst_vld", 32'(tx_vld), 0);
    check("rst_din", 32'(tx_din), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
`ifdef UART_TX_FIFO_STATS_EN
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_sent", 32'(sent_cnt), 0);
`endif

    // Single byte: launch three cycles after the write
    auto_mode = 1'b1;
    busy_len = 10;
    base = got.size();
    wc = cyc;
    push(8'h41);
    check("t1_level1", 32'(level), 1);
    step(1);
    check("t1_vld_early", 32'(tx_vld), 0);
    step(1);
    check("t1_vld", 32'(tx_vld), 1);
    check("t1_din", 32'(tx_din), 32'h41);
    check("t1_level0", 32'(level), 0);
    step(1);
    check("t1_vld_once", 32'(tx_vld), 0);
    step(20);
    check("t1_count", 32'(got.size() - base), 1);
    check("t1_latency", 32'(got_cyc[base] - wc), 3);
    check("t1_din_hold", 32'(tx_din), 32'h41);

    // Busy timeout: two bytes, busy never rises, four WAIT_HI cycles each
    do_reset();
    auto_mode = 1'b0;
    busy_force = 1'b0;
    base = got.size();
    wc = cyc;
    push(8'h55);
    push(8'h66);
    step(30);
    check("t4_count", 32'(got.size() - base), 2);
    check("t4_byte0", 32'(got[base]), 32'h55);
    check("t4_byte1", 32'(got[base+1]), 32'h66);
    check("t4_lat0", 32'(got_cyc[base] - wc), 3);
    check("t4_lat1", 32'(got_cyc[base+1] - wc), 9);
    check("t4_empty", 32'(empty), 1);

    // Wrap with pushes landing on LAUNCH cycles (launch period 6 with busy low)
    do_reset();
    base = got.size();
    for (int i = 0; i < 4; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 36; i++) begin
      wait_got(base + i + 1, 20, "t5_wait");
      v = got_cyc[base+i];
      goto_cycle(v + 5);
      check("t5_lvl_pre", 32'(level), 3);
      wr_din = 8'h84 + 8'(i);
      wr_vld = 1'b1;
      step(1);
      wr_vld = 1'b0;
      check("t5_lvl_post", 32'(level), 3);
    end
    wait_got(base + 40, 100, "t5_drain");
    step(10);
    check("t5_count", 32'(got.size() - base), 40);
    for (int i = 0; i < 40; i++) check("t5_order", 32'(got[base+i]), 32'h80 + i);
    check("t5_empty", 32'(empty), 1);

    // Burst into a busy transmitter, then drain at 20 busy cycles per byte
    do_reset();
    busy_force = 1'b1;
    base = got.size();
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 14) check("t2_notfull", 32'(full), 0);
    end
    check("t2_full", 32'(full), 1);
    check("t2_level", 32'(level), DEPTH);
    check("t2_ovf", 32'(overflow), 0);
    busy_len = 20;
    auto_mode = 1'b1;
    wait_got(base + 16, 600, "t2_drain");
    step(30);
    check("t2_count", 32'(got.size() - base), 16);
    for (int i = 0; i < 16; i++) check("t2_order", 32'(got[base+i]), i);
    for (int i = 0; i < 15; i++) check("t2_period", 32'(got_cyc[base+i+1] - got_cyc[base+i]), 24);

    // Reset while a launch is in progress: tx_vld must not appear
    do_reset();
    auto_mode = 1'b0;
    busy_force = 1'b0;
    base = got.size();
    push(8'h77);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t7_vld", 32'(tx_vld), 0);
    check("t7_level", 32'(level), 0);
    step(10);
    check("t7_count", 32'(got.size() - base), 0);

    // Overflow: full FIFO with busy stuck high drops 0xAA
    do_reset();
    busy_force = 1'b1;
    base = got.size();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    check("t3_ovf_before", 32'(overflow), 0);
    push(8'hAA);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_level", 32'(level), DEPTH);
    check("t3_full", 32'(full), 1);
`ifdef UART_TX_FIFO_STATS_EN
    check("t3_drop_cnt", 32'(drop_cnt), 1);
`endif
    busy_len = 3;
    auto_mode = 1'b1;
    wait_got(base + 16, 300, "t3_drain");
    step(20);
    check("t3_count", 32'(got.size() - base), 16);
    for (int i = 0; i < 16; i++) check("t3_order", 32'(got[base+i]), 32'h10 + i);
    check("t3_ovf_sticky", 32'(overflow), 1);
`ifdef UART_TX_FIFO_STATS_EN
    check("t3_sent_cnt", 32'(sent_cnt), 16);
`endif

    // Reset during WAIT_LO with bytes still queued
    busy_len = 10;
    base = got.size();
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    wait_got(base + 1, 50, "t6_first");
    v = got_cyc[base];
    goto_cycle(v + 4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_level", 32'(level), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_full", 32'(full), 0);
    check("t6_ovf", 32'(overflow), 0);
    check("t6_vld", 32'(tx_vld), 0);
    check("t6_din", 32'(tx_din), 0);
    step(60);
    check("t6_count", 32'(got.size() - base), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer between the `control` echo/handshake stage and `uart_tx`.
- Absorbs bursts from `control` and meters bytes into `uart_tx` one at a time, obeying its `busy` handshake.
- Without it, bytes that `control` issues while the transmitter is busy are lost. With it, up to `DEPTH` bytes queue and drain at the line rate selected by `baud_select`.

Parameters:
- `DATA_W`, 8, width of one byte/word.
- `DEPTH`, 16, FIFO entries; must be a power of 2, ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`, pointer width; derived, not overridden.
- `BUSY_WAIT`, 4, max cycles to wait for `tx_busy` to rise after a launch before the byte is treated as consumed.

Ports:
- `clk`  in  1  system clock (`CLOCK_50` domain).
- `rst`  in  1  synchronous reset, active-high.
- `wr_din`  in  `DATA_W`  byte from `control`.
- `wr_vld`  in  1  single-cycle write strobe from `control`.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  `ADDR_W+1`  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky; set when a write is dropped.
- `tx_busy`  in  1  busy from `uart_tx`.
- `tx_din`  out  `DATA_W`  byte to `uart_tx`.
- `tx_vld`  out  1  single-cycle launch strobe to `uart_tx`.

Behaviour:
- One clock (`clk`). Reset is synchronous, active-high (`rst`). All state updates on the rising edge.
- Reset values: `tx_vld` 0, `tx_din` 0, `full` 0, `empty` 1, `level` 0, `overflow` 0, FSM in IDLE, pointers 0.
- Reset mid-operation discards all contents. A `tx_vld` pulse in progress is not extended: `tx_vld` reads 0 in the cycle after the reset edge.
- Write path:
  - Write accepted iff `wr_vld`=1 and `full`=0 in that cycle; stored at `wr_ptr`, then `wr_ptr`+1.
  - `wr_vld`=1 with `full`=1 drops the byte and sets `overflow`. `overflow` is cleared only by `rst`.
  - `full` is evaluated on registered `level`. A launch (pop) in the same cycle does not make room for that cycle's write.
- Pointers: `ADDR_W` bits each, wrap modulo `DEPTH` naturally.
  - `level` changes by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
  - `full` = (`level`==`DEPTH`); `empty` = (`level`==0); both registered.
- Read FSM, 4 states:
  - IDLE: if `level`≠0 and `tx_busy`=0, go to LAUNCH.
  - LAUNCH, one cycle:
    - register `tx_din` ← `mem[rd_ptr]`, `tx_vld` ← 1 (visible the following cycle);
    - `rd_ptr`+1, `level`−1;
    - clear guard counter; go to WAIT_HI.
  - WAIT_HI:
    - `tx_vld` is 1 in the first cycle of WAIT_HI only.
    - if `tx_busy`=1, go to WAIT_LO;
    - else if guard counter = `BUSY_WAIT`−1, go to IDLE (byte considered consumed);
    - else increment guard counter.
  - WAIT_LO: if `tx_busy`=0, go to IDLE.
- `tx_din` holds its last value between launches.
- Latency: a write in cycle N into an empty FIFO with `tx_busy` low gives `tx_vld`=1 in cycle N+3.
- Back-to-back: the next launch follows `busy` falling, with IDLE taking a minimum of 1 cycle.

Optional Feature:
- Macro: `UART_TX_FIFO_STATS_EN`.
- With the macro defined, add outputs:
  - `drop_cnt[15:0]`: saturating count of dropped writes.
  - `sent_cnt[15:0]`: wrapping count of launches.
  - Both reset to 0.
- Without it, these ports and their counters are absent. All other behaviour is identical in both builds.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding typedef (IDLE/LAUNCH/WAIT_HI/WAIT_LO);
  - constant `UART_DATA_W`=8;
  - default depth constant.
- One natural sub-module, `sync_fifo_ram`: a `DEPTH`×`DATA_W` storage array with registered read and wr/rd pointer logic.
- The FSM and handshake stay in `uart_tx_fifo`.

Test Plan:
- Single byte: reset, then write 0x41 with `tx_busy` held 0, then `tx_busy` high for 10 cycles from the first `tx_vld`. Expect `tx_vld`=1 exactly once, 3 cycles after the write, `tx_din`=0x41; `level` goes 0→1→0.
- Burst: write 0x00..0x0F on consecutive cycles with `tx_busy` emulated (high 20 cycles per byte). Expect `full`=1 after the 16th write, `overflow`=0, and bytes emitted in order 0x00..0x0F, one `tx_vld` per `busy` low period.
- Overflow: fill 16 entries with `tx_busy`=1 stuck, then write 0xAA. Expect 0xAA absent from output, `overflow`=1, `level`=16; with STATS, `drop_cnt`=1.
- Busy-timeout: write 0x55, keep `tx_busy`=0. Expect a single `tx_vld`, return to IDLE after 4 WAIT_HI cycles, `empty`=1, no relaunch.
- Wrap and simultaneous push/pop: stream 40 bytes 0x80..0xA7 with writes coinciding with LAUNCH cycles. Expect output order preserved, `level` unchanged on coincident push/pop, pointers wrap with no corruption.
- Reset mid-burst: queue 5 bytes, assert `rst` during WAIT_LO. Expect `level`=0, `empty`=1, `overflow`=0, `tx_vld`=0 after the reset edge, and no further launches.
